// File: rtl/seller_pkg.sv
// Shared types and constants for the seller change-payout path.
package seller_pkg;

    localparam int unsigned AMT_W   = 8;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned EMPTY_W = 3;

    // Base money unit is 0.5 RMB; all amounts are counted in this unit.
    localparam int unsigned UNIT_HALF_RMB = 1;
    localparam int unsigned DENOM_HI      = 20 * UNIT_HALF_RMB;  // 10 RMB note
    localparam int unsigned DENOM_MID     = 2 * UNIT_HALF_RMB;   // 1 RMB coin
    localparam int unsigned DENOM_LO      = 1 * UNIT_HALF_RMB;   // 0.5 RMB coin

    localparam logic [SEL_W-1:0] SEL_HI  = 2'd2;
    localparam logic [SEL_W-1:0] SEL_MID = 2'd1;
    localparam logic [SEL_W-1:0] SEL_LO  = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_RELEASE,
        ST_DONE,
        ST_FAULT
    } disp_state_t;

    // Value in 0.5 RMB units of one item of the selected denomination.
    function automatic logic [AMT_W-1:0] denom_value(input logic [SEL_W-1:0] sel);
        case (sel)
            SEL_HI:  return AMT_W'(DENOM_HI);
            SEL_MID: return AMT_W'(DENOM_MID);
            default: return AMT_W'(DENOM_LO);
        endcase
    endfunction

endpackage

// File: rtl/denom_pick.sv
// Greedy denomination picker: largest non-empty denomination not exceeding remain.
module denom_pick
    import seller_pkg::*;
(
    input  logic [AMT_W-1:0]   remain,
    input  logic [EMPTY_W-1:0] empty,
    output logic [SEL_W-1:0]   sel,
    output logic               valid
);

    // Priority HI > MID > LO; valid drops when nothing fits or all candidates are empty.
    always_comb begin
        sel   = SEL_LO;
        valid = 1'b0;
        if (!empty[2] && (remain >= AMT_W'(DENOM_HI))) begin
            sel   = SEL_HI;
            valid = 1'b1;
        end else if (!empty[1] && (remain >= AMT_W'(DENOM_MID))) begin
            sel   = SEL_MID;
            valid = 1'b1;
        end else if (!empty[0] && (remain >= AMT_W'(DENOM_LO))) begin
            sel   = SEL_LO;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one item at a time over a 4-phase req/ack hopper handshake.
module change_dispenser
    import seller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AMT_W-1:0]   amount,
    input  logic               clear,
    input  logic [EMPTY_W-1:0] empty,
    input  logic               disp_ack,
    output logic               disp_req,
    output logic [SEL_W-1:0]   disp_sel,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [AMT_W-1:0]   remain,
    output logic [AMT_W-1:0]   item_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    disp_state_t        state, state_nxt;
    logic [AMT_W-1:0]   remain_nxt, item_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic               tmo_last;
    logic [SEL_W-1:0]   pick_sel;
    logic               pick_valid;

    denom_pick u_pick (
        .remain (remain),
        .empty  (empty),
        .sel    (pick_sel),
        .valid  (pick_valid)
    );

    assign tmo_last = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Next-state and datapath updates; the timeout counter restarts on every state change.
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        item_nxt   = item_cnt;
        sel_nxt    = disp_sel;
        tmo_nxt    = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    remain_nxt = amount;
                    item_nxt   = '0;
                    state_nxt  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (remain == '0) begin
                    state_nxt = ST_DONE;
                end else if (pick_valid) begin
                    sel_nxt   = pick_sel;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_REQ: begin
                if (disp_ack) begin
                    remain_nxt = remain - denom_value(disp_sel);
                    item_nxt   = (item_cnt == '1) ? item_cnt : item_cnt + AMT_W'(1);
                    state_nxt  = ST_RELEASE;
                end else if (tmo_last) begin
                    state_nxt = ST_FAULT;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!disp_ack) begin
                    state_nxt = ST_SELECT;
                end else if (tmo_last) begin
                    state_nxt = ST_FAULT;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (clear) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            remain   <= '0;
            item_cnt <= '0;
            disp_sel <= SEL_LO;
            tmo_cnt  <= '0;
            disp_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            remain   <= remain_nxt;
            item_cnt <= item_nxt;
            disp_sel <= sel_nxt;
            tmo_cnt  <= tmo_nxt;
            disp_req <= (state_nxt == ST_REQ);
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
            fault    <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser with a greedy reference model.
module tb_change_dispenser;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] amount = '0;
    logic       clear = 1'b0;
    logic [2:0] empty = '0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_sel;
    logic       busy, done, fault;
    logic [7:0] remain, item_cnt;

    change_dispenser #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .clear(clear),
        .empty(empty), .disp_ack(disp_ack), .disp_req(disp_req), .disp_sel(disp_sel),
        .busy(busy), .done(done), .fault(fault), .remain(remain), .item_cnt(item_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int sel; int rem; } item_t;
    typedef struct { bit is_fault; int rem; int items; } outcome_t;

    item_t    item_q[$];
    outcome_t out_q[$];
    int checks = 0;
    int errors = 0;
    int ack_mode = 0;  // 0: well-behaved hopper, 1: hopper never acks

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: greedy change breakdown with static hopper-empty flags.
    task automatic model(input int amt, input logic [2:0] emp);
        int vals[3];
        int sels[3];
        int rem;
        int n;
        int pick;
        vals = '{20, 2, 1};
        sels = '{2, 1, 0};
        rem = amt;
        n = 0;
        forever begin
            if (rem == 0) begin
                out_q.push_back('{1'b0, 0, n});
                break;
            end
            pick = -1;
            for (int k = 0; k < 3; k++)
                if (pick < 0 && !emp[sels[k]] && vals[k] <= rem) pick = k;
            if (pick < 0) begin
                out_q.push_back('{1'b1, rem, n});
                break;
            end
            item_q.push_back('{sels[pick], rem});
            rem -= vals[pick];
            n = (n < 255) ? n + 1 : 255;
        end
    endtask

    // Hopper: acks each request after a short random delay, releases after req drops.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_mode == 0 && rst && disp_req && !disp_ack) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 disp_ack = 1'b1;
                for (int i = 0; i < 50 && disp_req; i++) begin
                    @(posedge clk); #1;
                end
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 disp_ack = 1'b0;
            end
        end
    end

    // Monitor: compares each new request and each completion against the scoreboard.
    initial begin
        logic p_req, p_done, p_fault;
        item_t    it;
        outcome_t oc;
        p_req = 0; p_done = 0; p_fault = 0;
        forever begin
            @(negedge clk);
            if (disp_req && !p_req) begin
                if (item_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    it = item_q.pop_front();
                    chk("item_sel", int'(disp_sel), it.sel);
                    chk("item_remain", int'(remain), it.rem);
                end
            end
            if ((done && !p_done) || (fault && !p_fault)) begin
                if (out_q.size() == 0) chk("unexpected_end", 1, 0);
                else begin
                    oc = out_q.pop_front();
                    chk("end_is_fault", int'(fault), int'(oc.is_fault));
                    chk("end_remain", int'(remain), oc.rem);
                    chk("end_item_cnt", int'(item_cnt), oc.items);
                end
            end
            p_req = disp_req; p_done = done; p_fault = fault;
        end
    end

    // Issues one payout, waits for done/fault, exits fault via clear; returns first-response latency.
    task automatic run_txn(input logic [7:0] amt, input logic [2:0] emp, output int first);
        bit fin;
        model(int'(amt), emp);
        empty = emp;
        amount = amt;
        start = 1'b1;
        first = -1;
        fin = 0;
        for (int c = 1; c <= 6000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (first < 0 && (disp_req || done || fault)) first = c;
            if (done || fault) begin
                fin = 1;
                break;
            end
        end
        if (!fin) chk("txn_timeout", 0, 1);
        else if (done) begin
            chk("busy_at_done", int'(busy), 1);
            @(posedge clk); #1;
            chk("done_one_cycle", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end else begin
            chk("busy_in_fault", int'(busy), 1);
            chk("req_in_fault", int'(disp_req), 0);
            @(posedge clk); #1 clear = 1'b1;
            @(posedge clk); #1 clear = 1'b0;
            chk("fault_cleared", int'(fault), 0);
            chk("busy_cleared", int'(busy), 0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int cnt;
        bit seen;
        #12;
        chk("rst_req", int'(disp_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_remain", int'(remain), 0);
        chk("rst_item_cnt", int'(item_cnt), 0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_txn(8'd23, 3'b000, lat);
        chk("lat_first_req", lat, 2);
        run_txn(8'd4, 3'b010, lat);
        run_txn(8'd0, 3'b000, lat);
        chk("lat_done_zero", lat, 2);
        run_txn(8'd3, 3'b011, lat);
        chk("lat_fault_select", lat, 2);
        chk("fault_holds_remain", int'(remain), 3);

        // Hopper never acks: timeout after TMO cycles in REQ; a second start mid-REQ is ignored.
        ack_mode = 1;
        empty = 3'b000;
        model(20, 3'b000);
        item_q.delete();
        item_q.push_back('{2, 20});
        out_q.delete();
        out_q.push_back('{1'b1, 20, 0});
        amount = 8'd20;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (disp_req) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("tmo_req_seen", int'(seen), 1);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (!disp_req) break;
            cnt++;
            if (cnt == 3) begin
                start = 1'b1;
                amount = 8'd99;
            end else start = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("tmo_req_cycles", cnt, int'(TMO));
        chk("tmo_fault", int'(fault), 1);
        chk("tmo_remain", int'(remain), 20);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        chk("tmo_cleared", int'(fault), 0);
        ack_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a handshake.
        model(22, 3'b000);
        empty = 3'b000;
        amount = 8'd22;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (disp_req) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_mid_req_seen", int'(seen), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req", int'(disp_req), 0);
        chk("arst_sel", int'(disp_sel), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_remain", int'(remain), 0);
        chk("arst_item_cnt", int'(item_cnt), 0);
        chk("arst_fault", int'(fault), 0);
        item_q.delete();
        out_q.delete();
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_txn(8'd2, 3'b000, lat);
        chk("post_rst_items", int'(item_cnt), 1);

        // Randomized payouts.
        for (int t = 0; t < 25; t++) begin
            logic [7:0] a;
            logic [2:0] e;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 60));
            e = 3'($urandom_range(0, 7));
            run_txn(a, e, lat);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("item_q_drained", item_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sequences change payout once the purchase/cancel FSM has computed the change owed.
- Takes the change amount in 0.5 RMB units and breaks it greedily into 10 RMB notes, 1 RMB coins and 0.5 RMB coins.
- Drives a hopper one item at a time over a 4-phase req/ack handshake.
- Sits between the seller control FSM (start pulse, amount from the subtractor mux) and the physical dispenser. Reports done/fault back to the control FSM.

Parameters:
- DENOM_HI, 20, value of a 10 RMB note in 0.5 RMB units
- DENOM_MID, 2, value of a 1 RMB coin in 0.5 RMB units
- DENOM_LO, 1, value of a 0.5 RMB coin in 0.5 RMB units
- TIMEOUT_CYC, 1000, maximum cycles to wait for each ack edge before fault

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to pay out amount; sampled only in IDLE
- amount  in  8  change owed, 0.5 RMB units, sampled with start
- clear  in  1  leaves FAULT; ignored elsewhere
- empty  in  3  per-denomination hopper empty flags: [2]=HI, [1]=MID, [0]=LO
- disp_ack  in  1  hopper acknowledge
- disp_req  out  1  hopper request
- disp_sel  out  2  denomination select: 2=HI, 1=MID, 0=LO; stable while disp_req=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when payout completes
- fault  out  1  high while in FAULT
- remain  out  8  change still owed
- item_cnt  out  8  items dispensed since last accepted start; saturates at 255

Behaviour:
- Reset (rst=0, async): state=IDLE, disp_req=0, disp_sel=0, busy=0, done=0, fault=0, remain=0, item_cnt=0, timeout counter=0.
- States: IDLE, SELECT, REQ, RELEASE, DONE, FAULT.
- IDLE, start=1: remain<=amount, item_cnt<=0, go to SELECT. start=0: stay.
- SELECT:
  - remain==0: go to DONE.
  - Otherwise pick the largest denomination d with d<=remain and its empty bit=0. Priority HI>MID>LO.
  - Register disp_sel and go to REQ.
  - No eligible denomination: go to FAULT, remain held.
- REQ:
  - disp_req=1.
  - On disp_ack=1: remain<=remain-denom(disp_sel), item_cnt<=item_cnt+1, go to RELEASE.
  - Timeout counter starts at 0 on entry. Reaching TIMEOUT_CYC with no ack: go to FAULT, remain unchanged.
- RELEASE:
  - disp_req=0; wait for disp_ack=0, then go to SELECT.
  - Same timeout rule applies, restarted on entry.
- DONE: done=1 for exactly this cycle, then IDLE.
- FAULT:
  - fault=1, disp_req=0.
  - clear=1: go to IDLE. remain and item_cnt are held until the next start.
- Latency:
  - start to first disp_req=1: 2 cycles (IDLE→SELECT→REQ).
  - ack low to next disp_req: 2 cycles.
  - amount=0: done asserted 2 cycles after start.
- start while busy: ignored, with no effect on remain.
- empty is re-sampled each SELECT. A hopper emptying mid-payout falls through to smaller denominations.
- disp_ack high when REQ is entered (stuck ack): accepted as an ack.
- Subtraction never underflows, because denom<=remain is guaranteed by SELECT. remain is 8-bit unsigned.
- Reset mid-handshake: disp_req drops immediately (async). A partial payout is not resumed.

Decomposition:
- Shared package seller_pkg:
  - state enum for this block
  - denomination select encodings (SEL_HI=2, SEL_MID=1, SEL_LO=0)
  - unit constant definitions for 0.5 RMB
- Sub-module denom_pick (combinational): inputs remain and empty; outputs sel and valid. Unit-testable on its own.

Test Plan:
- amount=23, empty=000, ack returned 1 cycle after each req: sel sequence 2,1,0; remain 23→3→1→0; item_cnt=3; done pulse; busy falls with done.
- amount=4, empty=010: four LO handshakes; remain 4,3,2,1,0; item_cnt=4.
- amount=0: done high exactly 2 cycles after start; disp_req never asserted.
- amount=3, empty=011: fault after SELECT with remain=3; clear → IDLE, fault=0.
- amount=20, TIMEOUT_CYC=8, ack never asserted: fault at cycle 8 of REQ, remain=20, disp_req=0. Second start pulse mid-REQ in a separate run: ignored.
- rst low while disp_req=1 during amount=22 payout: all outputs at reset values asynchronously. After release, a new start with amount=2 pays one MID.
